// File: rtl/chk_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : chk_pkg
//  Description : Shared types and constants for the memory result checker.
//  Revision    : 1.0 - initial release
// ============================================================================
package chk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } chk_state_e;

    localparam int MODE_FIBO = 0;
    localparam int MODE_SORT = 1;

    // Width able to hold every 1-based item index plus the "no failure" value 0.
    function automatic int idx_width(input int n_items);
        return $clog2(n_items + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_result_checker_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_result_checker_if
//  Description : Start/status and memory read-port bundle of the result
//                checker. CHK_DIAG_EN adds the fail_actual/fail_expect lines.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mem_result_checker_if #(
    parameter int DATA_W  = 64,
    parameter int ADDR_W  = 64,
    parameter int N_ITEMS = 20
);
    localparam int IDX_W = chk_pkg::idx_width(N_ITEMS);

    logic              start;
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic              busy;
    logic              done;
    logic              pass;
    logic              timeout;
    logic [IDX_W-1:0]  fail_idx;
`ifdef CHK_DIAG_EN
    logic [DATA_W-1:0] fail_actual;
    logic [DATA_W-1:0] fail_expect;
`endif

    modport master (
        input  start, rd_valid, rd_data,
        output rd_req, rd_addr, busy, done, pass, timeout, fail_idx
`ifdef CHK_DIAG_EN
        , output fail_actual, fail_expect
`endif
    );

    modport slave (
        output start, rd_valid, rd_data,
        input  rd_req, rd_addr, busy, done, pass, timeout, fail_idx
`ifdef CHK_DIAG_EN
        , input fail_actual, fail_expect
`endif
    );

endinterface
`default_nettype wire

// File: rtl/mem_result_checker_ref_seq_gen.sv
`default_nettype none
// ============================================================================
//  Module      : ref_seq_gen
//  Description : Reference rule for the checker: expected value and match flag
//                for the current item, history advanced on each accepted word.
//  Revision    : 1.0 - initial release
// ============================================================================
module ref_seq_gen
    import chk_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int IDX_W  = 5,
    parameter int MODE   = MODE_FIBO
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear_i,
    input  logic              advance_i,
    input  logic [IDX_W-1:0]  idx_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] expected_o,
    output logic              match_o
);

    logic [DATA_W-1:0] prv1_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prv1_q <= '0;
        end else if (clear_i) begin
            prv1_q <= '0;
        end else if (advance_i) begin
            prv1_q <= data_i;
        end
    end

    generate
        if (MODE == MODE_SORT) begin : g_sort
            assign expected_o = prv1_q;
            assign match_o    = (idx_i == IDX_W'(1)) || ($signed(data_i) >= $signed(prv1_q));
        end else begin : g_fibo
            logic [DATA_W-1:0] prv2_q;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    prv2_q <= '0;
                end else if (clear_i) begin
                    prv2_q <= '0;
                end else if (advance_i) begin
                    prv2_q <= prv1_q;
                end
            end

            // Sum wraps modulo 2^DATA_W by construction.
            assign expected_o = (idx_i <= IDX_W'(2)) ? DATA_W'(1) : (prv1_q + prv2_q);
            assign match_o    = (data_i == expected_o);
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/mem_result_checker.sv
`default_nettype none
// ============================================================================
//  Module      : mem_result_checker
//  Description : Walks N_ITEMS memory words after a start rising edge and checks
//                them against a Fibonacci or sorted rule. CHK_DIAG_EN adds
//                capture of the failing actual/expected pair.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_result_checker
    import chk_pkg::*;
#(
    parameter int DATA_W    = 64,
    parameter int ADDR_W    = 64,
    parameter int N_ITEMS   = 20,
    parameter int BASE_ADDR = 1,
    parameter int ADDR_STEP = 1,
    parameter int MODE      = MODE_FIBO,
    parameter int TIMEOUT   = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    mem_result_checker_if.master bus
);

    localparam int               IDX_W    = idx_width(N_ITEMS);
    localparam int               CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ITEMS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    chk_state_e        state_q, state_d;
    logic              start_q, start_edge_q;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [IDX_W-1:0]  fail_idx_q, fail_idx_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              pass_q, pass_d;
    logic              tmo_q, tmo_d;
    logic              busy;
    logic              seq_clear, seq_advance, seq_match;
    logic [DATA_W-1:0] seq_expected;

    assign busy = (state_q == ST_REQ) || (state_q == ST_WAIT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            start_q      <= 1'b0;
            start_edge_q <= 1'b0;
            idx_q        <= '0;
            fail_idx_q   <= '0;
            cnt_q        <= '0;
            addr_q       <= ADDR_W'(BASE_ADDR);
            pass_q       <= 1'b0;
            tmo_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            start_q      <= bus.start;
            // Edges seen while busy are dropped here so one arriving on the
            // final accept cannot relaunch from DONE.
            start_edge_q <= bus.start & ~start_q & ~busy;
            idx_q        <= idx_d;
            fail_idx_q   <= fail_idx_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            pass_q       <= pass_d;
            tmo_q        <= tmo_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        fail_idx_d  = fail_idx_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        pass_d      = pass_q;
        tmo_d       = tmo_q;
        seq_clear   = 1'b0;
        seq_advance = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_edge_q) begin
                    state_d    = ST_REQ;
                    idx_d      = IDX_W'(1);
                    addr_d     = ADDR_W'(BASE_ADDR);
                    fail_idx_d = '0;
                    pass_d     = 1'b0;
                    tmo_d      = 1'b0;
                    seq_clear  = 1'b1;
                end
            end
            ST_REQ: begin
                state_d = ST_WAIT;
                cnt_d   = '0;
            end
            ST_WAIT: begin
                if (bus.rd_valid) begin
                    if (!seq_match) begin
                        state_d    = ST_DONE;
                        fail_idx_d = idx_q;
                    end else begin
                        seq_advance = 1'b1;
                        if (idx_q == LAST_IDX) begin
                            state_d = ST_DONE;
                            pass_d  = 1'b1;
                        end else begin
                            state_d = ST_REQ;
                            idx_d   = idx_q + IDX_W'(1);
                            addr_d  = addr_q + ADDR_W'(ADDR_STEP);
                        end
                    end
                end else if (cnt_q == CNT_LAST) begin
                    state_d    = ST_DONE;
                    tmo_d      = 1'b1;
                    fail_idx_d = idx_q;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    ref_seq_gen #(
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W),
        .MODE   (MODE)
    ) u_ref_seq_gen (
        .clk        (clk),
        .rst        (rst),
        .clear_i    (seq_clear),
        .advance_i  (seq_advance),
        .idx_i      (idx_q),
        .data_i     (bus.rd_data),
        .expected_o (seq_expected),
        .match_o    (seq_match)
    );

    assign bus.rd_req   = (state_q == ST_REQ);
    assign bus.rd_addr  = addr_q;
    assign bus.busy     = busy;
    assign bus.done     = (state_q == ST_DONE);
    assign bus.pass     = pass_q;
    assign bus.timeout  = tmo_q;
    assign bus.fail_idx = fail_idx_q;

`ifdef CHK_DIAG_EN
    logic [DATA_W-1:0] fail_actual_q, fail_expect_q;
    logic              capture;

    assign capture = (state_q == ST_WAIT) && bus.rd_valid && !seq_match;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fail_actual_q <= '0;
            fail_expect_q <= '0;
        end else if (seq_clear) begin
            fail_actual_q <= '0;
            fail_expect_q <= '0;
        end else if (capture) begin
            fail_actual_q <= bus.rd_data;
            fail_expect_q <= seq_expected;
        end
    end

    assign bus.fail_actual = fail_actual_q;
    assign bus.fail_expect = fail_expect_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_result_checker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_result_checker
//  Description : Directed self-checking bench: Fibonacci, sorted, timeout,
//                8-bit wrap, busy-start and mid-check reset scenarios.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_result_checker;
    import chk_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic mute_b = 1'b0;
    always #5 clk = ~clk;

    mem_result_checker_if #(.DATA_W(64), .ADDR_W(64), .N_ITEMS(20)) if_a ();
    mem_result_checker_if #(.DATA_W(64), .ADDR_W(64), .N_ITEMS(10)) if_b ();
    mem_result_checker_if #(.DATA_W(8),  .ADDR_W(8),  .N_ITEMS(14)) if_d ();

    mem_result_checker u_dut_a (.clk(clk), .rst(rst), .bus(if_a.master));

    mem_result_checker #(
        .MODE(MODE_SORT), .N_ITEMS(10), .TIMEOUT(4)
    ) u_dut_b (.clk(clk), .rst(rst), .bus(if_b.master));

    mem_result_checker #(
        .DATA_W(8), .ADDR_W(8), .N_ITEMS(14), .BASE_ADDR(16), .ADDR_STEP(8)
    ) u_dut_d (.clk(clk), .rst(rst), .bus(if_d.master));

    logic [63:0] mem_a [0:31];
    logic [63:0] mem_b [0:15];
    logic [7:0]  mem_d [0:255];
    logic [63:0] fib   [1:20];
    int req_a = 0, req_b = 0, req_d = 0;
    int n_checks = 0, n_errors = 0;

    // One-cycle memories
    always @(posedge clk) begin
        if_a.rd_valid <= if_a.rd_req;
        if_a.rd_data  <= mem_a[if_a.rd_addr[4:0]];
        if_b.rd_valid <= if_b.rd_req & ~mute_b;
        if_b.rd_data  <= mem_b[if_b.rd_addr[3:0]];
        if_d.rd_valid <= if_d.rd_req;
        if_d.rd_data  <= mem_d[if_d.rd_addr];
        if (if_a.rd_req === 1'b1) req_a <= req_a + 1;
        if (if_b.rd_req === 1'b1) req_b <= req_b + 1;
        if (if_d.rd_req === 1'b1) req_d <= req_d + 1;
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_start(input int w, input logic v);
        case (w)
            0:       if_a.start = v;
            1:       if_b.start = v;
            default: if_d.start = v;
        endcase
    endtask

    function automatic logic done_of(input int w);
        case (w)
            0:       return if_a.done;
            1:       return if_b.done;
            default: return if_d.done;
        endcase
    endfunction

    // lat counts clock edges after the one that samples the start edge.
    task automatic run_check(input int w, input bit toggle, input int budget, output int lat);
        @(negedge clk);
        set_start(w, 1'b1);
        @(posedge clk);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
            if (toggle && !done_of(w)) set_start(w, lat[0]);
        end while (!done_of(w) && lat < budget);
        check_val("done_reached", {63'd0, done_of(w)}, 64'd1);
        @(negedge clk);
        set_start(w, 1'b0);
    endtask

    initial begin
        int lat;
        int r0;
        bit found;
        logic [63:0] big;

        if_a.start = 1'b0;
        if_b.start = 1'b0;
        if_d.start = 1'b0;
        for (int i = 0; i < 32; i++) mem_a[i] = '0;
        for (int i = 0; i < 16; i++) mem_b[i] = '0;
        for (int i = 0; i < 256; i++) mem_d[i] = '0;
        fib[1] = 64'd1;
        fib[2] = 64'd1;
        for (int k = 3; k <= 20; k++) fib[k] = fib[k-1] + fib[k-2];
        for (int k = 1; k <= 20; k++) mem_a[k] = fib[k];
        for (int k = 1; k <= 14; k++) mem_d[16 + 8*(k-1)] = fib[k][7:0];
        for (int k = 1; k <= 10; k++) mem_b[k] = 64'(k - 4);

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_val("rst_done",     {63'd0, if_a.done},    64'd0);
        check_val("rst_busy",     {63'd0, if_a.busy},    64'd0);
        check_val("rst_rd_req",   {63'd0, if_a.rd_req},  64'd0);
        check_val("rst_pass",     {63'd0, if_a.pass},    64'd0);
        check_val("rst_timeout",  {63'd0, if_a.timeout}, 64'd0);
        check_val("rst_fail_idx", 64'(if_a.fail_idx),    64'd0);
        check_val("rst_addr_a",   if_a.rd_addr,          64'd1);
        check_val("rst_addr_d",   64'(if_d.rd_addr),     64'd16);

        // 1: Fibonacci pass, 20 items
        r0 = req_a;
        run_check(0, 1'b0, 100, lat);
        check_val("fib_latency",  64'(lat),              64'd41);
        check_val("fib_pass",     {63'd0, if_a.pass},    64'd1);
        check_val("fib_fail_idx", 64'(if_a.fail_idx),    64'd0);
        check_val("fib_timeout",  {63'd0, if_a.timeout}, 64'd0);
        check_val("fib_busy",     {63'd0, if_a.busy},    64'd0);
        check_val("fib_reqs",     64'(req_a - r0),       64'd20);
        check_val("fib_last_addr", if_a.rd_addr,         64'd20);
`ifdef CHK_DIAG_EN
        check_val("fib_diag_act", if_a.fail_actual, 64'd0);
        check_val("fib_diag_exp", if_a.fail_expect, 64'd0);
`endif

        // 2: Fibonacci mismatch at item 7, restarted from DONE
        mem_a[7] = 64'd14;
        r0 = req_a;
        run_check(0, 1'b0, 100, lat);
        check_val("fib7_pass",     {63'd0, if_a.pass},    64'd0);
        check_val("fib7_fail_idx", 64'(if_a.fail_idx),    64'd7);
        check_val("fib7_timeout",  {63'd0, if_a.timeout}, 64'd0);
        check_val("fib7_reqs",     64'(req_a - r0),       64'd7);
        check_val("fib7_latency",  64'(lat),              64'd15);
`ifdef CHK_DIAG_EN
        check_val("fib7_diag_act", if_a.fail_actual, 64'd14);
        check_val("fib7_diag_exp", if_a.fail_expect, 64'd13);
`endif
        mem_a[7] = 64'd13;

        // 3: sorted mode, signed compare
        run_check(1, 1'b0, 60, lat);
        check_val("sort_pass",     {63'd0, if_b.pass}, 64'd1);
        check_val("sort_fail_idx", 64'(if_b.fail_idx), 64'd0);
        check_val("sort_latency",  64'(lat),           64'd21);
        mem_b[5] = -64'sd9;
        run_check(1, 1'b0, 60, lat);
        check_val("sort5_pass",     {63'd0, if_b.pass}, 64'd0);
        check_val("sort5_fail_idx", 64'(if_b.fail_idx), 64'd5);
`ifdef CHK_DIAG_EN
        check_val("sort5_diag_act", if_b.fail_actual, -64'sd9);
        check_val("sort5_diag_exp", if_b.fail_expect, 64'd0);
`endif
        mem_b[5] = 64'd0;
        run_check(1, 1'b0, 60, lat);
        check_val("sort_equal_pass", {63'd0, if_b.pass}, 64'd1);

        // 4: missing rd_valid, TIMEOUT=4
        mute_b = 1'b1;
        r0 = req_b;
        run_check(1, 1'b0, 20, lat);
        check_val("tmo_latency",  64'(lat),              64'd6);
        check_val("tmo_timeout",  {63'd0, if_b.timeout}, 64'd1);
        check_val("tmo_pass",     {63'd0, if_b.pass},    64'd0);
        check_val("tmo_fail_idx", 64'(if_b.fail_idx),    64'd1);
`ifdef CHK_DIAG_EN
        check_val("tmo_diag_act", if_b.fail_actual, 64'd0);
`endif
        repeat (10) @(posedge clk);
        #1;
        check_val("tmo_reqs",      64'(req_b - r0),    64'd1);
        check_val("tmo_done_held", {63'd0, if_b.done}, 64'd1);
        mute_b = 1'b0;

        // 5: 8-bit wrap, byte-stepped addressing
        r0 = req_d;
        run_check(2, 1'b0, 80, lat);
        check_val("w8_pass",      {63'd0, if_d.pass}, 64'd1);
        check_val("w8_latency",   64'(lat),           64'd29);
        check_val("w8_reqs",      64'(req_d - r0),    64'd14);
        check_val("w8_last_addr", 64'(if_d.rd_addr),  64'd120);
        mem_d[120] = 8'd122;
        run_check(2, 1'b0, 80, lat);
        check_val("w8_bad_pass",     {63'd0, if_d.pass}, 64'd0);
        check_val("w8_bad_fail_idx", 64'(if_d.fail_idx), 64'd14);
        big = 64'd377;
        mem_d[120] = big[7:0];
        run_check(2, 1'b0, 80, lat);
        check_val("w8_trunc_pass", {63'd0, if_d.pass}, 64'd1);

        // 6a: start toggling while busy
        r0 = req_a;
        run_check(0, 1'b1, 100, lat);
        check_val("tog_latency", 64'(lat),           64'd41);
        check_val("tog_pass",    {63'd0, if_a.pass}, 64'd1);
        check_val("tog_reqs",    64'(req_a - r0),    64'd20);
        repeat (4) @(posedge clk);
        #1;
        check_val("tog_no_relaunch", {63'd0, if_a.done}, 64'd1);

        // 6b: reset during item 5
        @(negedge clk);
        if_a.start = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(posedge clk);
            #1;
            if (if_a.rd_req && if_a.rd_addr == 64'd5) found = 1'b1;
        end
        check_val("mid_reach_item5", {63'd0, found}, 64'd1);
        rst = 1'b0;
        if_a.start = 1'b0;
        #1;
        check_val("mid_rd_req",   {63'd0, if_a.rd_req}, 64'd0);
        check_val("mid_busy",     {63'd0, if_a.busy},   64'd0);
        check_val("mid_done",     {63'd0, if_a.done},   64'd0);
        check_val("mid_addr",     if_a.rd_addr,         64'd1);
        r0 = req_a;
        repeat (3) @(posedge clk);
        #1;
        check_val("mid_no_req", 64'(req_a - r0), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        r0 = req_a;
        run_check(0, 1'b0, 100, lat);
        check_val("post_rst_latency", 64'(lat),           64'd41);
        check_val("post_rst_pass",    {63'd0, if_a.pass}, 64'd1);
        check_val("post_rst_reqs",    64'(req_a - r0),    64'd20);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish, expected finish before 1000000");
        $fatal(1);
    end

endmodule
`default_nettype wire
